inst_loader: RTL and testbench
==============================

Name: inst_loader

Overview:
- Boot-time instruction loader that sits directly upstream of the monocycle core's instruction memory.
- Receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word into instruction memory through a single write port.
- Holds the core in reset until the whole image is loaded, then releases it.

Parameters:
- ADDR_W, 5, instruction-memory word-index width (32 words).
- MAX_WORDS, 32, largest accepted image length in words; must be ≤ 2**ADDR_W.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  reset; asynchronous, active-low.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts a byte; transfer occurs when in_valid & in_ready at a rising edge.
- reload  input  1  restart request; honoured only in DONE or ERR.
- wr_en  output  1  instruction-memory write strobe, one-cycle pulse.
- wr_addr  output  ADDR_W  word index being written.
- wr_data  output  32  assembled instruction word.
- core_rst_n  output  1  core reset, active-low; 0 while loading.
- busy  output  1  state is LEN0, LEN1, DATA or CHK.
- done  output  1  image loaded, core released.
- err  output  1  load aborted.
- words_loaded  output  ADDR_W+1  count of words written so far.

Behaviour:
- Reset (RST=0, async) puts outputs in this state:
  - state=LEN0; wr_en=0, wr_addr=0, wr_data=0.
  - core_rst_n=0, done=0, err=0, words_loaded=0.
  - in_ready=1, busy=1.
  - Instruction-memory contents are not touched. Reset mid-load abandons the load; words already written remain.
- Stream format:
  - len[7:0], then len[15:8].
  - Then len×4 payload bytes, least significant byte of each word first.
  - With the optional feature: one checksum byte at the end.
- in_ready=1 in LEN0, LEN1, DATA, CHK; 0 in DONE and ERR. It is combinational from state only.
- State transitions:
  - LEN0: on an accepted byte, store the low length byte and go to LEN1.
  - LEN1: on an accepted byte, form the 16-bit length.
    - len=0: go to DONE (or CHK if the feature is on).
    - len>MAX_WORDS: go to ERR.
    - Otherwise go to DATA; byte counter=0, word index=0.
  - DATA: each accepted byte shifts into a 32-bit assembly register at lane byte_cnt[1:0].
    - On the 4th byte of a word, at that same edge the registered outputs become wr_en=1, wr_addr=word index, wr_data=full word. words_loaded and the word index increment.
    - wr_en drops at the next edge unless another word completes there; back-to-back completion is impossible, since it needs at least 4 edges.
    - After the last word: go to DONE (or CHK).
  - DONE: on the first edge in DONE, core_rst_n=1 and done=1. core_rst_n therefore rises one cycle after the final wr_en pulse, so the write lands before the core fetches. Stays until reload or reset.
  - ERR: err=1, core_rst_n=0, no writes. Stays until reload or reset.
- reload=1 at an edge in DONE/ERR: go to LEN0. In that same edge core_rst_n=0, done=0, err=0, words_loaded=0. reload is ignored in other states.
- Byte gaps (in_valid low) of any length are allowed; nothing advances without a transfer.
- Bytes offered in DONE/ERR are not consumed (in_ready=0).

Optional Feature:
- Macro: INST_LOADER_CHECKSUM_EN.
- When defined:
  - State CHK follows DATA, or follows LEN1 when len=0.
  - A running XOR covers all payload bytes, excluding the length bytes, and is cleared on entry to LEN0.
  - The accepted CHK byte is compared to the XOR: equal goes to DONE, unequal goes to ERR.
  - Words are still written during DATA; only core release is gated.
- When undefined: no CHK state, no XOR register; the flow goes straight to DONE.

Test Plan:
- Reset release, then stream 02 00 13 05 10 00 93 05 20 00 → two wr_en pulses: addr0=0x00100513, then addr1=0x00200593. core_rst_n=1 and done=1 exactly one cycle after the second pulse; words_loaded=2.
- Stream 00 00 → no wr_en; done=1, core_rst_n=1. With the checksum macro, a trailing byte 00 is required; byte 01 instead gives err=1.
- Stream 21 00 (33 > MAX_WORDS) → err=1, in_ready=0, core_rst_n stays 0, no writes. reload pulse → LEN0, err=0, in_ready=1.
- Same two-word image with in_valid toggling 1/0 every cycle and random gaps → identical writes and values as the first scenario. A pulse on reload during DATA is ignored.
- RST asserted after 6 payload bytes of a 2-word image → immediate return to reset values. Word0 remains written; a fresh full stream then loads correctly.
- Checksum macro on, image 01 00 13 05 10 00, checksum 0x06 (13^05^10^00) → done=1. Checksum 0x07 → err=1; word0 still written, core_rst_n=0.

Source files
------------

// File: rtl/inst_loader.sv
// Boot-time instruction loader: assembles little-endian 32-bit words from a
// valid/ready byte stream, writes them into instruction memory and holds the
// core in reset until the image is complete.
// Optional trailing checksum byte: define INST_LOADER_CHECKSUM_EN.
module inst_loader #(
  parameter int ADDR_W    = 5,
  parameter int MAX_WORDS = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reload,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_LEN0,
    S_LEN1,
    S_DATA,
`ifdef INST_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  // State entered once the payload (or an empty image) is complete.
`ifdef INST_LOADER_CHECKSUM_EN
  localparam state_t S_END = S_CHK;
`else
  localparam state_t S_END = S_DONE;
`endif

  state_t            state, state_nx;
  logic [7:0]        len_lo;
  logic [ADDR_W:0]   len_words;
  logic [1:0]        byte_cnt;
  logic [23:0]       asm_q;
  logic [15:0]       len_full;
  logic [ADDR_W:0]   word_next;
  logic              xfer;
  logic              last_word;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign xfer      = in_valid & in_ready;
  assign len_full  = {in_data, len_lo};
  assign word_next = words_loaded + 1'b1;
  assign last_word = (byte_cnt == 2'd3) && (word_next == len_words);

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_LEN0;
    else      state <= state_nx;
  end

  // Next-state logic; in_ready/busy decode from state only.
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state)
      S_LEN0: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) state_nx = S_LEN1;
      end
      S_LEN1: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) begin
          if (len_full == 16'd0)                  state_nx = S_END;
          else if (len_full > 16'(MAX_WORDS))     state_nx = S_ERR;
          else                                    state_nx = S_DATA;
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer && last_word) state_nx = S_END;
      end
`ifdef INST_LOADER_CHECKSUM_EN
      S_CHK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) state_nx = (in_data == csum) ? S_DONE : S_ERR;
      end
`endif
      S_DONE:  if (reload) state_nx = S_LEN0;
      S_ERR:   if (reload) state_nx = S_LEN0;
      default: state_nx = S_LEN0;
    endcase
  end

  // Datapath: length capture, word assembly, write port and status flags.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      len_lo       <= '0;
      len_words    <= '0;
      byte_cnt     <= '0;
      asm_q        <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      core_rst_n   <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      wr_en <= 1'b0;
      case (state)
        S_LEN0: if (xfer) len_lo <= in_data;
        S_LEN1: begin
          if (xfer) begin
            len_words    <= len_full[ADDR_W:0];
            byte_cnt     <= '0;
            words_loaded <= '0;
          end
        end
        S_DATA: begin
          if (xfer) begin
            // Bytes arrive LSB first, so shifting in from the top leaves
            // the three earlier bytes in little-endian order.
            asm_q    <= {in_data, asm_q[23:8]};
            byte_cnt <= byte_cnt + 2'd1;
`ifdef INST_LOADER_CHECKSUM_EN
            csum     <= csum ^ in_data;
`endif
            if (byte_cnt == 2'd3) begin
              wr_en        <= 1'b1;
              wr_addr      <= words_loaded[ADDR_W-1:0];
              wr_data      <= {in_data, asm_q};
              words_loaded <= word_next;
            end
          end
        end
        S_DONE: begin
          if (reload) begin
            core_rst_n   <= 1'b0;
            done         <= 1'b0;
            words_loaded <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
          end else begin
            core_rst_n <= 1'b1;
            done       <= 1'b1;
          end
        end
        S_ERR: begin
          core_rst_n <= 1'b0;
          if (reload) begin
            err          <= 1'b0;
            words_loaded <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
          end else begin
            err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: directed and random byte streams
// compared against a stream-level reference model.
module tb_inst_loader;
  localparam int ADDR_W    = 5;
  localparam int MAX_WORDS = 32;

  typedef logic [7:0] bytes_t[$];

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              reload = 1'b0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              core_rst_n;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_loaded;

  int n_checks = 0;
  int n_pass   = 0;

  int          obs_addr[$];
  logic [31:0] obs_data[$];
  logic [31:0] mem [0:31];

  inst_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .CLK(clk), .RST(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .reload(reload), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .core_rst_n(core_rst_n), .busy(busy), .done(done),
    .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Instruction-memory stand-in and write log, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_en) begin
      obs_addr.push_back(int'(wr_addr));
      obs_data.push_back(wr_data);
      mem[wr_addr] = wr_data;
    end
  end

  // Reference: writes and outcome implied by a whole stream.
  function automatic void model(input bytes_t s, output int ea[$],
                                output logic [31:0] ed[$], output bit edone);
    int len;
    logic [7:0] x;
    ea.delete();
    ed.delete();
    len = int'(s[0]) + 256 * int'(s[1]);
    if (len > MAX_WORDS) begin
      edone = 1'b0;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < len; i++) begin
      ea.push_back(i);
      ed.push_back({s[2+4*i+3], s[2+4*i+2], s[2+4*i+1], s[2+4*i]});
      for (int k = 0; k < 4; k++) x = x ^ s[2+4*i+k];
    end
`ifdef INST_LOADER_CHECKSUM_EN
    edone = (s[2+4*len] == x);
`else
    edone = 1'b1;
`endif
  endfunction

  function automatic bytes_t add_csum(input bytes_t s);
    bytes_t r;
    logic [7:0] x;
    r = s;
    x = 8'h00;
    for (int i = 2; i < s.size(); i++) x = x ^ s[i];
`ifdef INST_LOADER_CHECKSUM_EN
    r.push_back(x);
`endif
    return r;
  endfunction

  // Starts and ends at a falling edge; in_valid is left low.
  task automatic send_byte(input logic [7:0] b, output bit ok);
    int unsigned t;
    t = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    ok = in_ready;
    if (ok) @(negedge clk);
    in_valid = 1'b0;
  endtask

  // mode 0: back-to-back, 1: valid toggles every cycle, 2: random gaps.
  task automatic send_stream(input string name, input bytes_t s,
                             input int mode, input int reload_at);
    bit ok, all_ok;
    all_ok = 1'b1;
    foreach (s[i]) begin
      if (i == reload_at) begin
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
      end
      send_byte(s[i], ok);
      all_ok = all_ok & ok;
      if (i != s.size() - 1) begin
        if (mode == 1) @(negedge clk);
        else if (mode == 2) repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    n_checks++;
    if (!all_ok) $display("FAIL %s accept: not all %0d bytes accepted", name, s.size());
    else n_pass++;
  endtask

  task automatic check_reload(input string name);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    n_checks++;
    if ({in_ready, busy, done, err, core_rst_n, words_loaded} !== {5'b11000, 6'd0})
      $display("FAIL %s reload: rdy/busy/done/err/crst/wl=%b%b%b%b%b/%0d want 11000/0",
               name, in_ready, busy, done, err, core_rst_n, words_loaded);
    else n_pass++;
  endtask

  task automatic run_image(input string name, input bytes_t s, input int mode,
                           input int reload_at);
    int ea[$];
    logic [31:0] ed[$];
    bit edone, elast;
    model(s, ea, ed, edone);
`ifdef INST_LOADER_CHECKSUM_EN
    elast = 1'b0;
`else
    elast = (ea.size() > 0);
`endif
    obs_addr.delete();
    obs_data.delete();
    send_stream(name, s, mode, reload_at);
    n_checks++;
    if ({wr_en, done, core_rst_n} !== {elast, 2'b00})
      $display("FAIL %s final_edge: wr_en/done/crst=%b%b%b want %b00",
               name, wr_en, done, core_rst_n, elast);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({done, err, core_rst_n} !== {edone, !edone, edone})
      $display("FAIL %s outcome: done/err/crst=%b%b%b want %b%b%b",
               name, done, err, core_rst_n, edone, !edone, edone);
    else n_pass++;
    n_checks++;
    if ({in_ready, busy, wr_en} !== 3'b000)
      $display("FAIL %s idle: rdy/busy/wr_en=%b%b%b want 000", name, in_ready, busy, wr_en);
    else n_pass++;
    n_checks++;
    if (int'(words_loaded) !== ea.size())
      $display("FAIL %s words_loaded: got %0d want %0d", name, words_loaded, ea.size());
    else n_pass++;
    n_checks++;
    if (obs_addr.size() !== ea.size())
      $display("FAIL %s write_count: got %0d want %0d", name, obs_addr.size(), ea.size());
    else begin
      n_pass++;
      foreach (ea[i]) begin
        n_checks++;
        if (obs_addr[i] !== ea[i] || obs_data[i] !== ed[i])
          $display("FAIL %s write%0d: got %0d:%h want %0d:%h",
                   name, i, obs_addr[i], obs_data[i], ea[i], ed[i]);
        else n_pass++;
      end
    end
  endtask

  bytes_t two_word;

  task automatic test_reset();
    n_checks++;
    if ({in_ready, busy, wr_en, done, err, core_rst_n} !== 6'b110000 ||
        wr_addr !== '0 || wr_data !== '0 || words_loaded !== '0)
      $display("FAIL reset: rdy/busy/we/done/err/crst=%b%b%b%b%b%b a=%0d d=%h wl=%0d want 110000 0 0 0",
               in_ready, busy, wr_en, done, err, core_rst_n, wr_addr, wr_data, words_loaded);
    else n_pass++;
  endtask

  task automatic test_two_word();
    run_image("two_word", two_word, 0, -1);
    check_reload("two_word");
  endtask

  task automatic test_zero_len();
    run_image("zero_len", add_csum('{8'h00, 8'h00}), 0, -1);
    check_reload("zero_len");
`ifdef INST_LOADER_CHECKSUM_EN
    run_image("zero_len_badck", '{8'h00, 8'h00, 8'h01}, 0, -1);
    check_reload("zero_len_badck");
`endif
  endtask

  task automatic test_oversize();
    run_image("oversize", '{8'h21, 8'h00}, 0, -1);
    // Bytes offered while in ERR must not be consumed or written.
    in_data  = 8'h5A;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if ({err, in_ready, core_rst_n} !== 3'b100 || obs_addr.size() != 0)
      $display("FAIL oversize_hold: err/rdy/crst=%b%b%b writes=%0d want 100 0",
               err, in_ready, core_rst_n, obs_addr.size());
    else n_pass++;
    check_reload("oversize");
  endtask

  task automatic test_gaps();
    run_image("toggle_gap", two_word, 1, 5);
    check_reload("toggle_gap");
    run_image("random_gap", two_word, 2, 7);
    check_reload("random_gap");
  endtask

  task automatic test_reset_midload();
    bytes_t s;
    s = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05};
    mem[0] = '0;
    send_stream("midload", s, 0, -1);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, busy, wr_en, done, err, core_rst_n} !== 6'b110000 || words_loaded !== '0)
      $display("FAIL midload_reset: rdy/busy/we/done/err/crst=%b%b%b%b%b%b wl=%0d want 110000 0",
               in_ready, busy, wr_en, done, err, core_rst_n, words_loaded);
    else n_pass++;
    n_checks++;
    if (mem[0] !== 32'h00100513)
      $display("FAIL midload_word0: got %h want 00100513", mem[0]);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_image("after_reset", two_word, 0, -1);
    check_reload("after_reset");
  endtask

`ifdef INST_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    run_image("ck_good", '{8'h01, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h06}, 0, -1);
    check_reload("ck_good");
    mem[0] = '0;
    run_image("ck_bad", '{8'h01, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h07}, 0, -1);
    n_checks++;
    if (mem[0] !== 32'h00100513 || core_rst_n !== 1'b0)
      $display("FAIL ck_bad_mem: word0=%h crst=%b want 00100513 0", mem[0], core_rst_n);
    else n_pass++;
    check_reload("ck_bad");
  endtask
`endif

  task automatic test_random();
    bytes_t s;
    int len, mode, rat;
    for (int k = 0; k < 12; k++) begin
      s.delete();
      case ($urandom_range(0, 9))
        0:       len = $urandom_range(MAX_WORDS + 1, 65535);
        1:       len = 0;
        default: len = $urandom_range(1, 8);
      endcase
      if (k == 0) len = MAX_WORDS;
      s.push_back(len[7:0]);
      s.push_back(len[15:8]);
      if (len <= MAX_WORDS) begin
        for (int i = 0; i < 4 * len; i++) s.push_back(8'($urandom));
        s = add_csum(s);
`ifdef INST_LOADER_CHECKSUM_EN
        if ($urandom_range(0, 3) == 0) s[s.size()-1] = s[s.size()-1] ^ 8'($urandom_range(1, 255));
`endif
      end
      mode = $urandom_range(0, 2);
      rat  = ($urandom_range(0, 1) == 1) ? $urandom_range(3, 6) : -1;
      run_image($sformatf("random%0d", k), s, mode, rat);
      check_reload($sformatf("random%0d", k));
    end
  endtask

  initial begin
    two_word = add_csum('{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                          8'h93, 8'h05, 8'h20, 8'h00});
    for (int i = 0; i < 32; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_two_word();
    test_zero_len();
    test_oversize();
    test_gaps();
    test_reset_midload();
`ifdef INST_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
